// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with 16x oversampling, a receive FIFO,
// sticky error flags and a level interrupt.
module uart_rx #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        wr,
    input  logic        valid,
    input  logic        rxd,
    output logic        irq
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    // Rounded divisor: (CLK_HZ + 8*BAUD) / (16*BAUD) - 1
    localparam int unsigned DivReset = (CLK_HZ + 8 * BAUD) / (16 * BAUD) - 1;
    localparam logic [15:0] DivRst   = 16'(DivReset);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [15:0]     div_q, tick_cnt_q;
    logic            tick, tick_clr;
    state_e          state_q, state_d;
    logic [3:0]      os_cnt_q, os_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_req, frame_err_set;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [8:0]      count_q;
    logic [7:0]      count8;
    logic            not_empty, full, do_push, overrun_set;
    logic            rx_en_q, irq_en_q, overrun_q, frame_err_q, last_valid_q, irq_q;
    logic            access_start, wr_en, pop, div_wr, flush;
    logic [1:0]      reg_sel;
    logic [31:0]     rd_data;
    logic            unused_bits;

    assign unused_bits = ^{addr[31:4], addr[1:0], din[31:16]};

    assign reg_sel      = addr[3:2];
    assign access_start = valid & ~last_valid_q;
    assign wr_en        = access_start & wr;
    assign not_empty    = (count_q != 9'd0);
    assign full         = (count_q == 9'(FIFO_DEPTH));
    assign pop          = access_start & ~wr & (reg_sel == 2'd0) & not_empty;
    assign div_wr       = wr_en & (reg_sel == 2'd2);
    assign flush        = wr_en & (reg_sel == 2'd3) & din[2];
    assign do_push      = push_req & ~full;
    assign overrun_set  = push_req & full;
    assign count8       = (count_q > 9'd255) ? 8'hFF : count_q[7:0];
    assign tick         = (tick_cnt_q == div_q);
    assign irq          = irq_q;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Oversample tick counter, 0..DIV, realigned on divisor write and frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= 16'd0;
        end else if (div_wr || tick_clr || tick) begin
            tick_cnt_q <= 16'd0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end
    end

    // Receive FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            os_cnt_q  <= 4'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Receive FSM next state: sample mid-bit, LSB first
    always_comb begin
        state_d       = state_q;
        os_cnt_d      = os_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tick_clr      = 1'b0;
        push_req      = 1'b0;
        frame_err_set = 1'b0;
        if (!rx_en_q) begin
            state_d  = StIdle;
            os_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rxd_prev_q && !rxd_sync_q) begin
                        state_d  = StStart;
                        tick_clr = 1'b1;
                        os_cnt_d = 4'd0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (os_cnt_q == 4'd7) begin
                            os_cnt_d  = 4'd0;
                            bit_cnt_d = 3'd0;
                            state_d   = rxd_sync_q ? StIdle : StData;
                        end else begin
                            os_cnt_d = os_cnt_q + 4'd1;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        os_cnt_d = os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd15) begin
                            shift_d = {rxd_sync_q, shift_q[7:1]};
                            if (bit_cnt_q == 3'd7) begin
                                state_d = StStop;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        os_cnt_d = os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd15) begin
                            if (rxd_sync_q) begin
                                push_req = 1'b1;
                                state_d  = StIdle;
                            end else begin
                                frame_err_set = 1'b1;
                                state_d       = StWaitHigh;
                            end
                        end
                    end
                end
                StWaitHigh: begin
                    if (rxd_sync_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FIFO pointers and count; flush wins over a simultaneous push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 9'd0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 9'd0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !pop)      count_q <= count_q + 9'd1;
            else if (pop && !do_push) count_q <= count_q - 9'd1;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= shift_q;
    end

    // Read data mux
    always_comb begin
        rd_data = 32'd0;
        unique case (reg_sel)
            2'd0: rd_data = not_empty ? {23'd0, 1'b1, mem_q[rd_ptr_q]} : 32'd0;
            2'd1: rd_data = {16'd0, count8, 4'd0, frame_err_q, overrun_q, full, not_empty};
            2'd2: rd_data = {16'd0, div_q};
            2'd3: rd_data = {30'd0, irq_en_q, rx_en_q};
            default: rd_data = 32'd0;
        endcase
    end

    // Control/status registers, bus edge detect, read data and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= DivRst;
            rx_en_q      <= 1'b1;
            irq_en_q     <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            last_valid_q <= 1'b0;
            irq_q        <= 1'b0;
            dout         <= 32'd0;
        end else begin
            last_valid_q <= valid;
            irq_q        <= irq_en_q & not_empty;
            if (div_wr) div_q <= din[15:0];
            if (wr_en && reg_sel == 2'd3) begin
                rx_en_q  <= din[0];
                irq_en_q <= din[1];
            end
            // New error events take priority over a clear in the same cycle
            overrun_q   <= overrun_set |
                           (overrun_q & ~(wr_en && reg_sel == 2'd1 && din[2]));
            frame_err_q <= frame_err_set |
                           (frame_err_q & ~(wr_en && reg_sel == 2'd1 && din[3]));
            // DATA keeps the popped value for the rest of the access
            if (valid && (access_start || reg_sel != 2'd0)) dout <= rd_data;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a queue-based receive model.
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        wr;
    logic        valid;
    logic        rxd;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  model_q[$];
    logic        model_ovr = 1'b0;
    logic        model_fe  = 1'b0;
    logic [31:0] rd;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          low_bits;
        logic [31:0] exp_data;
        logic        exp_fe;
    } vec_t;

    uart_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .wr    (wr),
        .valid (valid),
        .rxd   (rxd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [1:0] idx, input logic [31:0] wdata,
                       output logic [31:0] rdata);
        @(negedge clk);
        addr  = {28'd0, idx, 2'b00};
        din   = wdata;
        wr    = w;
        valid = 1'b1;
        repeat (2) @(negedge clk);
        rdata = dout;
        valid = 1'b0;
        wr    = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int low_bits,
                              input int bit_clks);
        rxd = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        rxd = stop;
        repeat (bit_clks) @(negedge clk);
        if (!stop) repeat (low_bits * bit_clks) @(negedge clk);
        rxd = 1'b1;
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (model_q.size() < 16) model_q.push_back(b);
        else model_ovr = 1'b1;
    endfunction

    function automatic logic [31:0] model_status();
        int n = model_q.size();
        logic [7:0] c = 8'(n);
        return {16'h0, c, 4'h0, model_fe, model_ovr, (n == 16), (n != 0)};
    endfunction

    task automatic read_data_check(input string name);
        logic [31:0] exp;
        exp = 32'd0;
        if (model_q.size() > 0) exp = {23'd0, 1'b1, model_q.pop_front()};
        bus(1'b0, 2'd0, 32'd0, rd);
        check(name, rd, exp);
    endtask

    task automatic status_check(input string name);
        bus(1'b0, 2'd1, 32'd0, rd);
        check(name, rd, model_status());
    endtask

    initial begin
        vec_t vecs[6];
        int   cyc;
        int   bitc;
        logic [7:0] b;

        vecs[0] = '{8'h3C, 1'b1, 0, 32'h13C, 1'b0};
        vecs[1] = '{8'h5A, 1'b0, 3, 32'h000, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 0, 32'h13C, 1'b0};
        vecs[3] = '{8'h81, 1'b1, 0, 32'h181, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 0, 32'h000, 1'b1};
        vecs[5] = '{8'hFE, 1'b1, 0, 32'h1FE, 1'b0};

        rst_n = 1'b0; addr = 32'd0; din = 32'd0; wr = 1'b0; valid = 1'b0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        status_check("reset_status");
        bus(1'b0, 2'd2, 32'd0, rd);
        check("reset_div", rd, 32'd26);
        bus(1'b0, 2'd3, 32'd0, rd);
        check("reset_ctrl", rd, 32'd1);

        // 0x55 at DIV=26 with irq enabled; measure receive-to-irq latency
        bus(1'b1, 2'd3, 32'h3, rd);
        cyc = 0;
        fork
            send_frame(8'h55, 1'b1, 0, 432);
            begin
                while (!irq && cyc < 6000) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        model_push(8'h55);
        checks++;
        if (cyc < 4100 || cyc > 4116) begin
            failures++;
            $display("FAIL irq_latency: got %0d clocks expected 4100..4116", cyc);
        end
        status_check("one_byte_status");
        read_data_check("one_byte_data");
        check("irq_after_pop", {31'd0, irq}, 32'd0);
        read_data_check("empty_read");
        status_check("empty_status");
        bus(1'b1, 2'd3, 32'h1, rd);

        // Back-to-back frames at DIV=26
        send_frame(8'h00, 1'b1, 0, 432); model_push(8'h00);
        send_frame(8'hFF, 1'b1, 0, 432); model_push(8'hFF);
        send_frame(8'hA5, 1'b1, 0, 432); model_push(8'hA5);
        status_check("b2b_status");
        for (int i = 0; i < 3; i++) read_data_check($sformatf("b2b_data%0d", i));

        // Short low glitch on idle line: 4 ticks
        rxd = 1'b0;
        repeat (4 * 27) @(negedge clk);
        rxd = 1'b1;
        repeat (16 * 27) @(negedge clk);
        status_check("glitch_status");

        // Table of frames at DIV=12, including framing errors
        bus(1'b1, 2'd2, 32'd12, rd);
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].low_bits, 208);
            bus(1'b0, 2'd1, 32'd0, rd);
            check($sformatf("vec%0d_status", i), rd,
                  {16'd0, 7'd0, vecs[i].exp_data[8], 4'd0, vecs[i].exp_fe, 2'b00,
                   vecs[i].exp_data[8]});
            bus(1'b0, 2'd0, 32'd0, rd);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            if (vecs[i].exp_fe) bus(1'b1, 2'd1, 32'h8, rd);
        end
        status_check("fe_cleared");

        // Disable reception mid-frame: nothing pushed
        fork
            send_frame(8'h99, 1'b1, 0, 208);
            begin
                repeat (3 * 208) @(negedge clk);
                bus(1'b1, 2'd3, 32'h0, rd);
            end
        join
        bus(1'b1, 2'd3, 32'h1, rd);
        status_check("abort_status");

        // Overflow with 17 frames at DIV=3
        bus(1'b1, 2'd2, 32'd3, rd);
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 13 + 7);
            send_frame(b, 1'b1, 0, 64);
            model_push(b);
        end
        status_check("ovf_status");
        for (int i = 0; i < 17; i++) read_data_check($sformatf("ovf_data%0d", i));
        bus(1'b1, 2'd1, 32'h4, rd);
        model_ovr = 1'b0;
        status_check("ovr_cleared");

        // Flush with 3 bytes buffered and irq enabled
        bus(1'b1, 2'd3, 32'h3, rd);
        for (int i = 0; i < 3; i++) begin
            send_frame(8'(8'hC0 + i), 1'b1, 0, 64);
            model_push(8'(8'hC0 + i));
        end
        status_check("pre_flush_status");
        check("pre_flush_irq", {31'd0, irq}, 32'd1);
        bus(1'b1, 2'd3, 32'h7, rd);
        model_q.delete();
        status_check("flush_status");
        check("flush_irq", {31'd0, irq}, 32'd0);
        bus(1'b0, 2'd3, 32'd0, rd);
        check("flush_ctrl", rd, 32'h3);
        bus(1'b1, 2'd3, 32'h1, rd);

        // Randomized bursts against the queue model
        for (int r = 0; r < 3; r++) begin
            int div = $urandom_range(1, 3);
            int n   = $urandom_range(1, 12);
            int k;
            bitc = 16 * (div + 1);
            bus(1'b1, 2'd2, 32'(div), rd);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send_frame(b, 1'b1, 0, bitc);
                model_push(b);
            end
            status_check($sformatf("rnd%0d_status", r));
            k = $urandom_range(0, model_q.size());
            for (int i = 0; i < k; i++) read_data_check($sformatf("rnd%0d_data%0d", r, i));
            if (model_ovr) begin
                bus(1'b1, 2'd1, 32'h4, rd);
                model_ovr = 1'b0;
            end
        end
        while (model_q.size() > 0) read_data_check("rnd_drain");
        status_check("rnd_final_status");

        // Reset asserted mid-frame with a byte buffered and irq pending
        bus(1'b1, 2'd3, 32'h3, rd);
        send_frame(8'h42, 1'b1, 0, bitc);
        repeat (2) @(negedge clk);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        bus(1'b0, 2'd1, 32'd0, rd);
        fork
            send_frame(8'h77, 1'b1, 0, bitc);
            begin
                repeat (3 * bitc) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("midreset_irq", {31'd0, irq}, 32'd0);
                check("midreset_dout", dout, 32'd0);
            end
        join
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        status_check("post_reset_status");
        bus(1'b0, 2'd2, 32'd0, rd);
        check("post_reset_div", rd, 32'd26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
